// File: rtl/clock_set_controller.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_controller
// Purpose  : Time-setting sequencer for the digital clock: field selection,
//            up/down pulse generation with auto-repeat, timeout and blink.
// Revision : 1.0 - initial release
// ============================================================================
module clock_set_controller #(
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000,
    parameter int unsigned TIMEOUT      = 500000000,
    parameter int unsigned BLINK_HALF   = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       tick_in,
    output logic       tick_out,
    output logic [1:0] field_sel,
    output logic       set_ena_hour,
    output logic       set_ena_min,
    output logic       set_ena_sec,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic       blink
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOUR = 2'd1,
        ST_MIN  = 2'd2,
        ST_SEC  = 2'd3
    } state_t;

    localparam logic [31:0] c_delay_load  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] c_rate_load   = 32'(REPEAT_RATE - 1);
    localparam logic [31:0] c_timeout_last = 32'(TIMEOUT - 1);
    localparam logic [31:0] c_blink_last  = 32'(BLINK_HALF - 1);

    state_t      r_state;
    logic        r_prev_mode;
    logic        r_prev_up;
    logic        r_prev_down;
    logic [31:0] r_rep_cnt;
    logic        r_rep_active;
    logic        r_rep_up;
    logic [31:0] r_idle_cnt;
    logic [31:0] r_blink_cnt;
    logic        r_blink;
    logic        r_up;
    logic        r_down;
    logic        r_ena_hour;
    logic        r_ena_min;
    logic        r_ena_sec;

    logic        w_rise_mode;
    logic        w_rise_up;
    logic        w_rise_down;
    logic        w_any_rise;
    logic        w_in_set;
    state_t      w_next_state;
    logic        w_up_gen;
    logic        w_down_gen;
    logic        w_pulse;
    logic [31:0] w_rep_cnt_next;
    logic        w_rep_active_next;
    logic        w_rep_up_next;
    logic [31:0] w_idle_next;
    logic [31:0] w_blink_cnt_next;
    logic        w_blink_next;

    assign w_rise_mode = btn_mode & ~r_prev_mode;
    assign w_rise_up   = btn_up   & ~r_prev_up;
    assign w_rise_down = btn_down & ~r_prev_down;
    assign w_any_rise  = w_rise_mode | w_rise_up | w_rise_down;
    assign w_in_set    = (r_state != ST_RUN);

    always_comb begin
        w_next_state      = r_state;
        w_up_gen          = 1'b0;
        w_down_gen        = 1'b0;
        w_pulse           = 1'b0;
        w_rep_cnt_next    = '0;
        w_rep_active_next = 1'b0;
        w_rep_up_next     = r_rep_up;
        w_idle_next       = '0;
        w_blink_cnt_next  = '0;
        w_blink_next      = 1'b0;

        // A mode press or both buttons held disarms the repeat engine outright
        if (w_in_set && !w_rise_mode && !(btn_up && btn_down)) begin
            if (w_rise_up) begin
                w_up_gen          = 1'b1;
                w_rep_cnt_next    = c_delay_load;
                w_rep_active_next = 1'b1;
                w_rep_up_next     = 1'b1;
            end else if (w_rise_down) begin
                w_down_gen        = 1'b1;
                w_rep_cnt_next    = c_delay_load;
                w_rep_active_next = 1'b1;
                w_rep_up_next     = 1'b0;
            end else if (r_rep_active && (r_rep_up ? btn_up : btn_down)) begin
                w_rep_active_next = 1'b1;
                if (r_rep_cnt == '0) begin
                    w_up_gen       = r_rep_up;
                    w_down_gen     = ~r_rep_up;
                    w_rep_cnt_next = c_rate_load;
                end else begin
                    w_rep_cnt_next = r_rep_cnt - 32'd1;
                end
            end
        end
        w_pulse = w_up_gen | w_down_gen;

        if (w_rise_mode) begin
            unique case (r_state)
                ST_RUN:  w_next_state = ST_HOUR;
                ST_HOUR: w_next_state = ST_MIN;
                ST_MIN:  w_next_state = ST_SEC;
                ST_SEC:  w_next_state = ST_RUN;
                default: w_next_state = ST_RUN;
            endcase
        end else if (w_in_set && !w_any_rise && !w_pulse &&
                     (r_idle_cnt == c_timeout_last)) begin
            w_next_state = ST_RUN;
        end

        if (w_next_state != ST_RUN) begin
            if ((w_next_state != r_state) || w_any_rise || w_pulse)
                w_idle_next = '0;
            else
                w_idle_next = r_idle_cnt + 32'd1;

            // Field stays lit on entry and while being adjusted
            if ((w_next_state != r_state) || w_pulse) begin
                w_blink_next     = 1'b1;
                w_blink_cnt_next = '0;
            end else if (r_blink_cnt == c_blink_last) begin
                w_blink_next     = ~r_blink;
                w_blink_cnt_next = '0;
            end else begin
                w_blink_next     = r_blink;
                w_blink_cnt_next = r_blink_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_prev_mode  <= 1'b0;
            r_prev_up    <= 1'b0;
            r_prev_down  <= 1'b0;
            r_rep_cnt    <= '0;
            r_rep_active <= 1'b0;
            r_rep_up     <= 1'b0;
            r_idle_cnt   <= '0;
            r_blink_cnt  <= '0;
            r_blink      <= 1'b0;
            r_up         <= 1'b0;
            r_down       <= 1'b0;
            r_ena_hour   <= 1'b0;
            r_ena_min    <= 1'b0;
            r_ena_sec    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_prev_mode  <= btn_mode;
            r_prev_up    <= btn_up;
            r_prev_down  <= btn_down;
            r_rep_cnt    <= w_rep_cnt_next;
            r_rep_active <= w_rep_active_next;
            r_rep_up     <= w_rep_up_next;
            r_idle_cnt   <= w_idle_next;
            r_blink_cnt  <= w_blink_cnt_next;
            r_blink      <= w_blink_next;
            r_up         <= w_up_gen;
            r_down       <= w_down_gen;
            r_ena_hour   <= (w_next_state == ST_HOUR);
            r_ena_min    <= (w_next_state == ST_MIN);
            r_ena_sec    <= (w_next_state == ST_SEC);
        end
    end

    assign tick_out     = tick_in & (r_state == ST_RUN);
    assign field_sel    = r_state;
    assign set_ena_hour = r_ena_hour;
    assign set_ena_min  = r_ena_min;
    assign set_ena_sec  = r_ena_sec;
    assign up_pulse     = r_up;
    assign down_pulse   = r_down;
    assign blink        = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_set_controller
// Purpose  : Directed and random checking of clock_set_controller against a
//            timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_set_controller;

    localparam int RD = 8;
    localparam int RR = 4;
    localparam int TO = 50;
    localparam int BH = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       tick_in = 1'b0;
    logic       tick_out;
    logic [1:0] field_sel;
    logic       set_ena_hour;
    logic       set_ena_min;
    logic       set_ena_sec;
    logic       up_pulse;
    logic       down_pulse;
    logic       blink;

    clock_set_controller #(
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .TIMEOUT      (TO),
        .BLINK_HALF   (BH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_mode     (btn_mode),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .tick_in      (tick_in),
        .tick_out     (tick_out),
        .field_sel    (field_sel),
        .set_ena_hour (set_ena_hour),
        .set_ena_min  (set_ena_min),
        .set_ena_sec  (set_ena_sec),
        .up_pulse     (up_pulse),
        .down_pulse   (down_pulse),
        .blink        (blink)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_up  = 0;
    int n_dn  = 0;

    // Reference model: times are edge indices; pulses and blink derive from
    // the time since the hold started / last activity / last blink restart.
    int m_t = 0;
    int m_mode = 0;
    bit m_pm, m_pu, m_pd;
    int hold_dir = 0;
    int t_first = 0;
    int last_act = 0;
    int blink_ref = 0;
    bit e_up, e_down, e_blink;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pm = 0; m_pu = 0; m_pd = 0;
        hold_dir = 0;
        e_up = 0; e_down = 0; e_blink = 0;
    endtask

    task automatic model_step();
        bit rm, ru, rd, in_set, pulse;
        int k, old;
        rm = btn_mode && !m_pm;
        ru = btn_up && !m_pu;
        rd = btn_down && !m_pd;
        in_set = (m_mode != 0);
        old = m_mode;
        e_up = 0;
        e_down = 0;
        if (!in_set || rm || (btn_up && btn_down)) hold_dir = 0;
        else if (ru) begin e_up = 1; hold_dir = 1; t_first = m_t; end
        else if (rd) begin e_down = 1; hold_dir = 2; t_first = m_t; end
        else if (hold_dir == 1 && btn_up) begin
            k = m_t - t_first;
            e_up = (k >= RD) && ((k - RD) % RR == 0);
        end else if (hold_dir == 2 && btn_down) begin
            k = m_t - t_first;
            e_down = (k >= RD) && ((k - RD) % RR == 0);
        end else hold_dir = 0;
        pulse = e_up || e_down;

        if (rm) m_mode = (m_mode + 1) % 4;
        else if (in_set && !ru && !rd && !pulse && (m_t - last_act == TO)) m_mode = 0;

        if (m_mode != 0 && (m_mode != old || rm || ru || rd || pulse)) last_act = m_t;
        if (m_mode == 0) e_blink = 0;
        else begin
            if (m_mode != old || pulse) blink_ref = m_t;
            e_blink = (((m_t - blink_ref) / BH) % 2) == 0;
        end
        m_pm = btn_mode; m_pu = btn_up; m_pd = btn_down;
        m_t++;
    endtask

    task automatic compare_all();
        chk("field_sel", 32'(field_sel), 32'(m_mode));
        chk("set_ena_hour", 32'(set_ena_hour), 32'(m_mode == 1));
        chk("set_ena_min", 32'(set_ena_min), 32'(m_mode == 2));
        chk("set_ena_sec", 32'(set_ena_sec), 32'(m_mode == 3));
        chk("up_pulse", 32'(up_pulse), 32'(e_up));
        chk("down_pulse", 32'(down_pulse), 32'(e_down));
        chk("blink", 32'(blink), 32'(e_blink));
        chk("tick_out", 32'(tick_out), 32'(tick_in && m_mode == 0));
    endtask

    // Inputs are set by the caller before each call; they stay stable across the edge
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
            n_up += int'(up_pulse);
            n_dn += int'(down_pulse);
            compare_all();
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_field"}, 32'(field_sel), 32'd0);
        chk({tag, "_ena"}, 32'({set_ena_hour, set_ena_min, set_ena_sec}), 32'd0);
        chk({tag, "_pulses"}, 32'({up_pulse, down_pulse}), 32'd0);
        chk({tag, "_blink"}, 32'(blink), 32'd0);
        chk({tag, "_tick"}, 32'(tick_out), 32'(tick_in));
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; cyc(1);
        btn_mode = 1'b0; cyc(1);
    endtask

    initial begin
        int ub, db;
        #1 reset = 1'b1;
        #1 check_reset("rst_init");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin tick_in = i[0]; cyc(1); end
        tick_in = 1'b0;

        for (int p = 0; p < 4; p++) begin
            btn_mode = 1'b1; cyc(1);
            chk("mode_step", 32'(field_sel), 32'((p + 1) % 4));
            cyc(2);
            btn_mode = 1'b0; cyc(3);
        end
        btn_mode = 1'b1; cyc(20);
        btn_mode = 1'b0; cyc(1);
        chk("mode_hold_once", 32'(field_sel), 32'd1);

        press_mode();
        ub = n_up; db = n_dn;
        btn_up = 1'b1; cyc(30);
        chk("repeat_up_count", 32'(n_up - ub), 32'd7);
        chk("repeat_down_count", 32'(n_dn - db), 32'd0);
        btn_up = 1'b0; cyc(2);

        press_mode(); press_mode(); press_mode();
        chk("back_to_hour", 32'(field_sel), 32'd1);
        ub = n_up; db = n_dn;
        btn_up = 1'b1; btn_down = 1'b1; cyc(10);
        btn_down = 1'b0; cyc(10);
        chk("conflict_pulses", 32'((n_up - ub) + (n_dn - db)), 32'd0);
        btn_up = 1'b0; cyc(1);
        btn_up = 1'b1; cyc(1);
        chk("rearm_up", 32'(up_pulse), 32'd1);
        btn_up = 1'b0; cyc(1);

        ub = n_up;
        btn_mode = 1'b1; btn_up = 1'b1; cyc(1);
        chk("mode_prio_field", 32'(field_sel), 32'd2);
        chk("mode_prio_pulse", 32'(up_pulse), 32'd0);
        cyc(10);
        chk("mode_prio_norepeat", 32'(n_up - ub), 32'd0);
        btn_mode = 1'b0; btn_up = 1'b0; cyc(1);

        btn_mode = 1'b1; cyc(1);
        btn_mode = 1'b0; cyc(49);
        chk("timeout_before", 32'(field_sel), 32'd3);
        cyc(1);
        chk("timeout_at", 32'(field_sel), 32'd0);

        press_mode(); press_mode();
        btn_mode = 1'b1; cyc(1);
        btn_mode = 1'b0; cyc(39);
        btn_down = 1'b1; cyc(1);
        chk("timeout_down_pulse", 32'(down_pulse), 32'd1);
        btn_down = 1'b0; cyc(49);
        chk("timeout2_before", 32'(field_sel), 32'd3);
        cyc(1);
        chk("timeout2_at", 32'(field_sel), 32'd0);

        btn_mode = 1'b1; tick_in = 1'b1; cyc(1);
        chk("blink_entry", 32'(blink), 32'd1);
        btn_mode = 1'b0; tick_in = 1'b0; cyc(4);
        chk("blink_hold", 32'(blink), 32'd1);
        cyc(1);
        chk("blink_toggle", 32'(blink), 32'd0);
        tick_in = 1'b1; cyc(1);
        chk("tick_gated", 32'(tick_out), 32'd0);
        tick_in = 1'b0; btn_up = 1'b1; cyc(1);
        chk("blink_forced", 32'(blink), 32'd1);
        btn_up = 1'b0; cyc(4);
        chk("blink_restart_hold", 32'(blink), 32'd1);
        cyc(1);
        chk("blink_restart_toggle", 32'(blink), 32'd0);

        press_mode();
        btn_up = 1'b1; cyc(3);
        #2 reset = 1'b1;
        #1 check_reset("rst_async");
        model_reset();
        @(posedge clk); #1;
        check_reset("rst_held");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin tick_in = ~i[0]; cyc(1); end
        btn_up = 1'b0; tick_in = 1'b0; cyc(1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 11) == 0) btn_up = ~btn_up;
            if ($urandom_range(0, 13) == 0) btn_down = ~btn_down;
            tick_in = ($urandom_range(0, 3) == 0);
            cyc(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
